sdram_arbit: RTL and testbench
==============================

# sdram_arbit

Central arbiter for the SDRAM controller. It owns the SDRAM command/address pins and hands them to one sub-module at a time: the power-up init sequencer, the auto-refresh module, the write module or the read module. Refresh always wins, and write and read alternate when both are pending. A watchdog reclaims the bus if a granted master never signals completion.

## Interface
- TIMEOUT, 1023: maximum cycles a write/read/refresh grant may be held before forced release (10-bit counter, 1..1023).
- sysclk_100M  in  1  system clock, 100 MHz, rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_cmd / init_addr / init_bank  in  4/13/2  init sequencer bus.
- init_end  in  1  level, high once power-up init is complete.
- refresh_req  in  1  refresh module request (level, held until ack).
- refresh_end  in  1  one-cycle pulse, refresh sequence done.
- refresh_cmd / refresh_addr / refresh_bank  in  4/13/2  refresh module bus.
- write_req, write_end, write_cmd, write_addr, write_bank  in  1/1/4/13/2  write module, same semantics as refresh.
- read_req, read_end, read_cmd, read_addr, read_bank  in  1/1/4/13/2  read module (arbit_read_req / arbit_read_end side), same semantics.
- refresh_ack / write_ack / read_ack  out  1 each  grant level, high for the whole granted state.
- sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n} to the SDRAM.
- sdram_addr  out  13  SDRAM address bus.
- sdram_bank  out  2  SDRAM bank address.
- timeout_err  out  1  one-cycle pulse on watchdog release.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. The state register is the only control state. The other registers are the 10-bit watchdog counter and the 1-bit last_rw flag (0 = read served last, 1 = write served last).
- INIT: the mux passes init_*. When init_end = 1, the next state is ARBIT.
- ARBIT: drives NOP (4'b0111), addr 0, bank 0. Priority on the current cycle's inputs:
  - refresh_req goes to AREF.
  - If only one of write_req / read_req is high, it goes to its state.
  - If both are high, go to READ when last_rw = 1, else WRITE.
  - If none is high, stay in ARBIT.
- AREF / WRITE / READ:
  - The mux passes that master's cmd/addr/bank. Its ack = 1 and the other acks = 0.
  - The matching *_end returns to ARBIT.
  - Entering WRITE sets last_rw = 1. Entering READ clears it.
- No preemption: refresh_req raised during WRITE/READ waits for the end pulse. The write/read modules handle their own early termination on refresh_req.
- *_end from a non-granted master is ignored.
- Watchdog:
  - Cleared on every entry into AREF/WRITE/READ, and increments each cycle in those states.
  - On reaching TIMEOUT with no end pulse: state goes to ARBIT, timeout_err pulses for one cycle, and the ack drops.
- init_end falling after INIT is ignored. Only reset returns to INIT.

## Timing
- Reset (rst high, asynchronous): state = INIT, last_rw = 0, counter = 0, all acks = 0, timeout_err = 0. While rst is high, sdram_cmd = 4'b0111, sdram_addr = 0 and sdram_bank = 0 are forced regardless of init_*.
- Reset mid-grant: the ack drops immediately (asynchronous) and the bus is forced to NOP.
- Acks and the output mux decode from the registered state, combinationally. The granted master's cmd reaches sdram_cmd in the same cycle it drives it, with zero added latency.
- Grant latency: a request seen in ARBIT at edge N gives ack high from after edge N, i.e. first SDRAM command possible in cycle N+1.
- Release: an *_end sampled at edge M drops the ack after edge M. The bus is NOP for at least one ARBIT cycle, so back-to-back grants are separated by ≥1 NOP cycle.
- A request held across the release edge is re-granted after exactly one ARBIT cycle.
- Simultaneous refresh_req, write_req and read_req in ARBIT: refresh is granted, and the write/read order afterward follows last_rw.
- Simultaneous *_end and watchdog expiry: a normal release, with no timeout_err.

## Test plan
- Reset/init: rst high for 10 cycles, then init_cmd = 4'b0010 with init_end low. Required: NOP and all acks 0 during rst, then sdram_cmd = 4'b0010. Raise init_end: ARBIT, sdram_cmd = 4'b0111.
- Read grant: read_req high in ARBIT. Required: read_ack high the next cycle, with sdram_cmd/addr/bank equal to read_cmd/addr/bank (e.g. 4'b0011, 13'h0400, 2'b01). A read_end pulse drops read_ack after one edge, and the bus returns to NOP.
- Priority: refresh_req, write_req and read_req all rise in the same cycle with last_rw = 0. Required grant order: AREF, WRITE, READ, each separated by one NOP cycle.
- Alternation: write_req and read_req held continuously, each end pulsed 20 cycles after its ack. Required grants alternate W, R, W, R.
- Watchdog: with TIMEOUT = 16, grant write and never pulse write_end. Required: write_ack low and timeout_err = 1 for one cycle, 16 cycles after entry.
- Async reset mid-read: assert rst 3 cycles into READ. Required: read_ack = 0 and sdram_cmd = 4'b0111 before the next clock edge, and state = INIT after rst is released.

Source files
------------

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter. It hands the SDRAM cmd/addr/bank pins to one
// master at a time: the init sequencer, auto-refresh, write or read. Refresh
// wins over write and read, and write and read alternate when both are
// pending. A watchdog reclaims a grant that is never released.
//
// state | meaning
// INIT  | power-up, init sequencer drives the bus
// ARBIT | idle, bus at NOP, picks the next master
// AREF  | refresh module granted
// WRITE | write module granted
// READ  | read module granted
module sdram_arbit #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        sysclk_100M,
  input  logic        rst,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic [1:0]  init_bank,
  input  logic        init_end,
  input  logic        refresh_req,
  input  logic        refresh_end,
  input  logic [3:0]  refresh_cmd,
  input  logic [12:0] refresh_addr,
  input  logic [1:0]  refresh_bank,
  input  logic        write_req,
  input  logic        write_end,
  input  logic [3:0]  write_cmd,
  input  logic [12:0] write_addr,
  input  logic [1:0]  write_bank,
  input  logic        read_req,
  input  logic        read_end,
  input  logic [3:0]  read_cmd,
  input  logic [12:0] read_addr,
  input  logic [1:0]  read_bank,
  output logic        refresh_ack,
  output logic        write_ack,
  output logic        read_ack,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        timeout_err
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  // The grant is released at the edge where the counter would reach TIMEOUT.
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

  state_t     state, state_nxt;
  logic [9:0] wd_cnt;
  logic       last_rw;
  logic       wd_expire;
  logic       granted;

  assign granted = (state == AREF) || (state == WRITE) || (state == READ);

  // Next-state decode: priority pick in ARBIT, end pulse or watchdog release otherwise.
  always_comb begin
    state_nxt = state;
    wd_expire = 1'b0;
    case (state)
      INIT: begin
        if (init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        if (refresh_req)                state_nxt = AREF;
        else if (write_req && read_req) state_nxt = last_rw ? READ : WRITE;
        else if (write_req)             state_nxt = WRITE;
        else if (read_req)              state_nxt = READ;
      end
      AREF: begin
        if (refresh_end) state_nxt = ARBIT;
        else if (wd_cnt == WD_LAST) begin
          state_nxt = ARBIT;
          wd_expire = 1'b1;
        end
      end
      WRITE: begin
        if (write_end) state_nxt = ARBIT;
        else if (wd_cnt == WD_LAST) begin
          state_nxt = ARBIT;
          wd_expire = 1'b1;
        end
      end
      READ: begin
        if (read_end) state_nxt = ARBIT;
        else if (wd_cnt == WD_LAST) begin
          state_nxt = ARBIT;
          wd_expire = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // State, watchdog, write/read fairness flag and timeout pulse registers.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      wd_cnt      <= '0;
      last_rw     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= wd_expire;
      // Held at zero outside a grant, so every grant starts from a clean count.
      wd_cnt      <= granted ? wd_cnt + 10'd1 : '0;
      if (state == ARBIT && state_nxt == WRITE) last_rw <= 1'b1;
      if (state == ARBIT && state_nxt == READ)  last_rw <= 1'b0;
    end
  end

  // Bus mux and acks decoded from the registered state; reset forces NOP.
  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_addr  = '0;
    sdram_bank  = '0;
    refresh_ack = 1'b0;
    write_ack   = 1'b0;
    read_ack    = 1'b0;
    case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = init_bank;
      end
      AREF: begin
        sdram_cmd   = refresh_cmd;
        sdram_addr  = refresh_addr;
        sdram_bank  = refresh_bank;
        refresh_ack = 1'b1;
      end
      WRITE: begin
        sdram_cmd  = write_cmd;
        sdram_addr = write_addr;
        sdram_bank = write_bank;
        write_ack  = 1'b1;
      end
      READ: begin
        sdram_cmd  = read_cmd;
        sdram_addr = read_addr;
        sdram_bank = read_bank;
        read_ack   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      sdram_cmd   = CMD_NOP;
      sdram_addr  = '0;
      sdram_bank  = '0;
      refresh_ack = 1'b0;
      write_ack   = 1'b0;
      read_ack    = 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: two instances (default watchdog and a 16-cycle one)
// share one set of inputs; a per-cycle owner model predicts both.
module tb_sdram_arbit;

  localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;
  localparam int TMO_A = 1023, TMO_B = 16;

  typedef struct packed {
    int owner;
    int held;
    bit last_w;
    bit terr;
  } mdl_t;

  localparam mdl_t MDL_RST = '{owner: O_INIT, held: 0, last_w: 1'b0, terr: 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  init_cmd = 4'b0010;
  logic [12:0] init_addr = 13'h0abc;
  logic [1:0]  init_bank = 2'b10;
  logic        init_end = 1'b0;
  logic        refresh_req = 1'b0, refresh_end = 1'b0;
  logic [3:0]  refresh_cmd = 4'b0001;
  logic [12:0] refresh_addr = 13'h0123;
  logic [1:0]  refresh_bank = 2'b11;
  logic        write_req = 1'b0, write_end = 1'b0;
  logic [3:0]  write_cmd = 4'b0100;
  logic [12:0] write_addr = 13'h0155;
  logic [1:0]  write_bank = 2'b10;
  logic        read_req = 1'b0, read_end = 1'b0;
  logic [3:0]  read_cmd = 4'b0011;
  logic [12:0] read_addr = 13'h0400;
  logic [1:0]  read_bank = 2'b01;

  logic        a_ref_ack, a_wr_ack, a_rd_ack, a_terr;
  logic [3:0]  a_cmd;
  logic [12:0] a_addr;
  logic [1:0]  a_bank;
  logic        b_ref_ack, b_wr_ack, b_rd_ack, b_terr;
  logic [3:0]  b_cmd;
  logic [12:0] b_addr;
  logic [1:0]  b_bank;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_arbit dut_a (
    .sysclk_100M(clk), .rst(rst),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank), .init_end(init_end),
    .refresh_req(refresh_req), .refresh_end(refresh_end),
    .refresh_cmd(refresh_cmd), .refresh_addr(refresh_addr), .refresh_bank(refresh_bank),
    .write_req(write_req), .write_end(write_end),
    .write_cmd(write_cmd), .write_addr(write_addr), .write_bank(write_bank),
    .read_req(read_req), .read_end(read_end),
    .read_cmd(read_cmd), .read_addr(read_addr), .read_bank(read_bank),
    .refresh_ack(a_ref_ack), .write_ack(a_wr_ack), .read_ack(a_rd_ack),
    .sdram_cmd(a_cmd), .sdram_addr(a_addr), .sdram_bank(a_bank), .timeout_err(a_terr)
  );

  sdram_arbit #(.TIMEOUT(TMO_B)) dut_b (
    .sysclk_100M(clk), .rst(rst),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank), .init_end(init_end),
    .refresh_req(refresh_req), .refresh_end(refresh_end),
    .refresh_cmd(refresh_cmd), .refresh_addr(refresh_addr), .refresh_bank(refresh_bank),
    .write_req(write_req), .write_end(write_end),
    .write_cmd(write_cmd), .write_addr(write_addr), .write_bank(write_bank),
    .read_req(read_req), .read_end(read_end),
    .read_cmd(read_cmd), .read_addr(read_addr), .read_bank(read_bank),
    .refresh_ack(b_ref_ack), .write_ack(b_wr_ack), .read_ack(b_rd_ack),
    .sdram_cmd(b_cmd), .sdram_addr(b_addr), .sdram_bank(b_bank), .timeout_err(b_terr)
  );

  always #5 clk = ~clk;

  // Owner model: who holds the bus, how long, and who of write/read went last.
  function automatic mdl_t mdl_step(input mdl_t m, input int tmo);
    mdl_t n;
    bit   done;
    n = m;
    n.terr = 1'b0;
    if (m.owner == O_INIT) begin
      if (init_end) n.owner = O_IDLE;
    end else if (m.owner == O_IDLE) begin
      n.held = 0;
      if (refresh_req)                n.owner = O_REF;
      else if (write_req && read_req) n.owner = m.last_w ? O_RD : O_WR;
      else if (write_req)             n.owner = O_WR;
      else if (read_req)              n.owner = O_RD;
      if (n.owner == O_WR) n.last_w = 1'b1;
      if (n.owner == O_RD) n.last_w = 1'b0;
    end else begin
      done = (m.owner == O_REF && refresh_end) || (m.owner == O_WR && write_end) ||
             (m.owner == O_RD && read_end);
      n.held = m.held + 1;
      if (done) n.owner = O_IDLE;
      else if (n.held >= tmo) begin
        n.owner = O_IDLE;
        n.terr  = 1'b1;
      end
    end
    return n;
  endfunction

  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= MDL_RST;
      mb <= MDL_RST;
    end else begin
      ma <= mdl_step(ma, TMO_A);
      mb <= mdl_step(mb, TMO_B);
    end
  end

  task automatic check_dut(input string nm, input mdl_t m, input logic [22:0] act);
    logic [22:0] exp;
    exp = {4'b0111, 13'h0, 2'b00, 3'b000, m.terr};
    if (!rst) begin
      case (m.owner)
        O_INIT: exp[22:4] = {init_cmd, init_addr, init_bank};
        O_REF:  exp[22:1] = {refresh_cmd, refresh_addr, refresh_bank, 3'b100};
        O_WR:   exp[22:1] = {write_cmd, write_addr, write_bank, 3'b010};
        O_RD:   exp[22:1] = {read_cmd, read_addr, read_bank, 3'b001};
        default: ;
      endcase
    end
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t {cmd,addr,bank,acks,terr} got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  int log_a[$];
  int terr_cnt_b = 0;
  logic pa_ref = 1'b0, pa_wr = 1'b0, pa_rd = 1'b0;

  // Per-cycle compare of both instances against the model, plus grant logging.
  always @(negedge clk) begin
    check_dut("dut_a", ma, {a_cmd, a_addr, a_bank, a_ref_ack, a_wr_ack, a_rd_ack, a_terr});
    check_dut("dut_b", mb, {b_cmd, b_addr, b_bank, b_ref_ack, b_wr_ack, b_rd_ack, b_terr});
    if (a_ref_ack && !pa_ref) log_a.push_back(O_REF);
    if (a_wr_ack && !pa_wr)   log_a.push_back(O_WR);
    if (a_rd_ack && !pa_rd)   log_a.push_back(O_RD);
    pa_ref <= a_ref_ack;
    pa_wr  <= a_wr_ack;
    pa_rd  <= a_rd_ack;
    if (b_terr) terr_cnt_b <= terr_cnt_b + 1;
  end

  // Auto-responding masters (index 0 refresh, 1 write, 2 read), driven from dut_a acks.
  bit auto_en[3]  = '{1'b0, 1'b0, 1'b0};
  bit hold_req[3] = '{1'b0, 1'b0, 1'b0};
  int end_dly[3]  = '{3, 3, 3};
  int hcnt[3]     = '{0, 0, 0};

  task automatic tick();
    logic ack;
    @(posedge clk);
    #1;
    refresh_end = 1'b0;
    write_end   = 1'b0;
    read_end    = 1'b0;
    for (int m = 0; m < 3; m++) begin
      if (auto_en[m]) begin
        ack = (m == 0) ? a_ref_ack : (m == 1) ? a_wr_ack : a_rd_ack;
        if (ack) begin
          hcnt[m]++;
          if (!hold_req[m]) begin
            if (m == 0) refresh_req = 1'b0;
            else if (m == 1) write_req = 1'b0;
            else read_req = 1'b0;
          end
          if (hcnt[m] == end_dly[m]) begin
            if (m == 0) refresh_end = 1'b1;
            else if (m == 1) write_end = 1'b1;
            else read_end = 1'b1;
          end
        end else begin
          hcnt[m] = 0;
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    int terr0;

    // Reset then init
    ticks(10);
    chk("rst_cmd", 32'(a_cmd), 32'h7);
    chk("rst_acks", 32'({a_ref_ack, a_wr_ack, a_rd_ack}), 0);
    rst = 1'b0;
    #1;
    chk("init_pass_cmd", 32'(a_cmd), 32'h2);
    tick();
    chk("init_hold_cmd", 32'(a_cmd), 32'h2);
    init_end = 1'b1;
    tick();
    chk("arbit_nop", 32'(a_cmd), 32'h7);
    init_end = 1'b0;

    // Single read grant and release
    read_req = 1'b1;
    tick();
    chk("rd_ack", 32'(a_rd_ack), 1);
    chk("rd_cmd", 32'(a_cmd), 32'h3);
    chk("rd_addr", 32'(a_addr), 32'h400);
    chk("rd_bank", 32'(a_bank), 1);
    read_req = 1'b0;
    ticks(2);
    read_end = 1'b1;
    tick();
    chk("rd_release_ack", 32'(a_rd_ack), 0);
    chk("rd_release_nop", 32'(a_cmd), 32'h7);
    ticks(2);

    // Three simultaneous requests, read served last: REF, WRITE, READ
    base = log_a.size();
    auto_en = '{1'b1, 1'b1, 1'b1};
    hold_req = '{1'b0, 1'b0, 1'b0};
    end_dly = '{3, 3, 3};
    refresh_req = 1'b1;
    write_req = 1'b1;
    read_req = 1'b1;
    ticks(30);
    if (log_a.size() - base >= 3) begin
      chk("prio_0", log_a[base], O_REF);
      chk("prio_1", log_a[base + 1], O_WR);
      chk("prio_2", log_a[base + 2], O_RD);
    end else chk("prio_count", log_a.size() - base, 3);

    // Write and read held continuously: W, R, W, R
    base = log_a.size();
    auto_en = '{1'b0, 1'b1, 1'b1};
    hold_req = '{1'b0, 1'b1, 1'b1};
    end_dly = '{3, 20, 20};
    write_req = 1'b1;
    read_req = 1'b1;
    ticks(70);
    hold_req = '{1'b0, 1'b0, 1'b0};
    ticks(60);
    if (log_a.size() - base >= 4) begin
      chk("alt_0", log_a[base], O_WR);
      chk("alt_1", log_a[base + 1], O_RD);
      chk("alt_2", log_a[base + 2], O_WR);
      chk("alt_3", log_a[base + 3], O_RD);
    end else chk("alt_count", log_a.size() - base, 4);
    chk("alt_reqs_low", 32'({write_req, read_req}), 0);

    // End pulse on the exact expiry edge of the 16-cycle instance: no timeout_err
    terr0 = terr_cnt_b;
    auto_en = '{1'b0, 1'b1, 1'b0};
    end_dly = '{3, TMO_B, 3};
    write_req = 1'b1;
    ticks(25);
    chk("end_at_expiry_no_terr", terr_cnt_b - terr0, 0);
    auto_en = '{1'b0, 1'b0, 1'b0};

    // Watchdog on the 16-cycle instance
    write_req = 1'b1;
    cnt = 0;
    while (!b_wr_ack && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("wd_grant_seen", 32'(b_wr_ack), 1);
    write_req = 1'b0;
    cnt = 0;
    while (b_wr_ack && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("wd_ack_cycles", cnt, TMO_B);
    chk("wd_terr_pulse", 32'(b_terr), 1);
    chk("wd_a_still_granted", 32'(a_wr_ack), 1);
    tick();
    chk("wd_terr_one_cycle", 32'(b_terr), 0);
    write_end = 1'b1;
    tick();
    chk("wd_a_release", 32'(a_wr_ack), 0);
    chk("wd_b_no_second_terr", 32'(b_terr), 0);
    ticks(2);

    // Asynchronous reset three cycles into READ
    read_req = 1'b1;
    cnt = 0;
    while (!a_rd_ack && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("rst_rd_grant_seen", 32'(a_rd_ack), 1);
    read_req = 1'b0;
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rd_ack", 32'(a_rd_ack), 0);
    chk("async_rst_nop", 32'(a_cmd), 32'h7);
    chk("async_rst_b_nop", 32'(b_cmd), 32'h7);
    ticks(2);
    rst = 1'b0;
    tick();
    chk("post_rst_init_cmd", 32'(a_cmd), 32'h2);
    chk("post_rst_init_addr", 32'(a_addr), 32'h0abc);
    init_end = 1'b1;
    tick();
    chk("post_rst_arbit", 32'(a_cmd), 32'h7);
    ticks(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
